// File: rtl/result_drain_pkg.sv
// Shared constants and FSM state type for the result drain block.
package result_drain_pkg;

   localparam int unsigned NUM_BANKS     = 16;
   localparam int unsigned BANK_W        = 32;
   localparam int unsigned ADDR_W        = 4;
   localparam int unsigned BEAT_W        = 128;
   localparam int unsigned BEATS_PER_ROW = 4;

   // Derived widths
   localparam int unsigned ROW_W      = NUM_BANKS * BANK_W;
   localparam int unsigned A_W        = NUM_BANKS * ADDR_W;
   localparam int unsigned BEAT_IDX_W = $clog2(BEATS_PER_ROW);

   typedef enum logic [1:0] {
      StIdle,
      StRead,
      StCap,
      StSend
   } state_e;

endpackage

// File: rtl/result_drain.sv
// Result drain: reads one row across all output memory banks, buffers it, and
// streams it out as BEATS_PER_ROW valid/ready beats, row by row up to rows_m1.
module result_drain
   import result_drain_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [ADDR_W-1:0]     rows_m1,
   output logic [NUM_BANKS-1:0]  CEN,
   output logic [NUM_BANKS-1:0]  WEN,
   output logic [A_W-1:0]        A,
   input  logic [ROW_W-1:0]      Q,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [BEAT_W-1:0]     out_data,
   output logic                  out_last,
   output logic                  busy,
   output logic                  done
);

   state_e                r_state;
   state_e                w_state_nxt;
   logic [ADDR_W-1:0]     r_row;
   logic [ADDR_W-1:0]     w_row_nxt;
   logic [ADDR_W-1:0]     r_rows_m1;
   logic [ADDR_W-1:0]     w_rows_m1_nxt;
   logic [BEAT_IDX_W-1:0] r_beat;
   logic [BEAT_IDX_W-1:0] w_beat_nxt;
   logic [ROW_W-1:0]      r_buf;
   logic                  w_buf_load;
   logic                  r_done;
   logic                  w_done_nxt;

   logic                  w_accept;
   logic                  w_last_beat;
   logic                  w_last_row;

   assign w_accept    = out_valid & out_ready;
   assign w_last_beat = (r_beat == BEAT_IDX_W'(BEATS_PER_ROW - 1));
   assign w_last_row  = (r_row == r_rows_m1);

   // State, counters and latched row limit
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= StIdle;
         r_row     <= '0;
         r_rows_m1 <= '0;
         r_beat    <= '0;
         r_done    <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_row     <= w_row_nxt;
         r_rows_m1 <= w_rows_m1_nxt;
         r_beat    <= w_beat_nxt;
         r_done    <= w_done_nxt;
      end
   end

   // Row buffer captures the memory read data during CAP
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_buf <= '0;
      end else if (w_buf_load) begin
         r_buf <= Q;
      end
   end

   // Next-state logic: one READ, one CAP, then BEATS_PER_ROW accepted beats per row
   always_comb begin
      w_state_nxt   = r_state;
      w_row_nxt     = r_row;
      w_rows_m1_nxt = r_rows_m1;
      w_beat_nxt    = r_beat;
      w_done_nxt    = 1'b0;
      w_buf_load    = 1'b0;
      unique case (r_state)
         StIdle: begin
            if (start) begin
               w_state_nxt   = StRead;
               w_rows_m1_nxt = rows_m1;
               w_row_nxt     = '0;
               w_beat_nxt    = '0;
            end
         end
         StRead: begin
            w_state_nxt = StCap;
         end
         StCap: begin
            w_state_nxt = StSend;
            w_buf_load  = 1'b1;
         end
         StSend: begin
            if (w_accept) begin
               if (w_last_beat) begin
                  w_beat_nxt = '0;
                  if (w_last_row) begin
                     // Row counter stays at rows_m1, so it can never wrap
                     w_state_nxt = StIdle;
                     w_done_nxt  = 1'b1;
                  end else begin
                     w_state_nxt = StRead;
                     w_row_nxt   = r_row + 1'b1;
                  end
               end else begin
                  w_beat_nxt = r_beat + 1'b1;
               end
            end
         end
         default: begin
            w_state_nxt = StIdle;
         end
      endcase
   end

   // Beat mux: beat b carries banks 4b..4b+3 of the buffered row
   always_comb begin
      out_data = '0;
      for (int b = 0; b < BEATS_PER_ROW; b++) begin
         if (r_beat == BEAT_IDX_W'(b)) begin
            out_data = r_buf[b*BEAT_W +: BEAT_W];
         end
      end
   end

   // Memory interface: all banks read together; the address is the row counter,
   // which only changes on entry to READ and so holds its value elsewhere
   always_comb begin
      CEN = (r_state == StRead) ? '0 : '1;
      WEN = '1;
      A   = {NUM_BANKS{r_row}};
   end

   // Stream handshake and status
   always_comb begin
      out_valid = (r_state == StSend);
      out_last  = out_valid & w_last_beat & w_last_row;
      busy      = (r_state != StIdle);
      done      = r_done;
   end

endmodule

// File: tb/tb_result_drain.sv
// Self-checking bench for result_drain: behavioural memory plus a queue of
// expected beats built directly from the bank/row/beat layout.
module tb_result_drain;
   import result_drain_pkg::*;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         start;
   logic [3:0]   rows_m1;
   logic [15:0]  CEN;
   logic [15:0]  WEN;
   logic [63:0]  A;
   logic [511:0] Q;
   logic         out_valid;
   logic         out_ready;
   logic [127:0] out_data;
   logic         out_last;
   logic         busy;
   logic         done;

   int n_pass  = 0;
   int n_total = 0;

   logic [31:0] mem [16][16];
   logic [31:0] q_r [16];

   result_drain dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .rows_m1   (rows_m1),
      .CEN       (CEN),
      .WEN       (WEN),
      .A         (A),
      .Q         (Q),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_last  (out_last),
      .busy      (busy),
      .done      (done)
   );

   always #5 clk = ~clk;

   // Synchronous-read memory: data appears the cycle after a selected bank is read
   always @(posedge clk) begin
      for (int i = 0; i < 16; i++) begin
         if (!CEN[i]) q_r[i] <= mem[i][A[4*i +: 4]];
      end
   end

   always_comb begin
      Q = '0;
      for (int i = 0; i < 16; i++) Q[32*i +: 32] = q_r[i];
   end

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_cen"},   128'(CEN),       128'hFFFF);
      check({tag, "_wen"},   128'(WEN),       128'hFFFF);
      check({tag, "_a"},     128'(A),         128'h0);
      check({tag, "_valid"}, 128'(out_valid), 128'h0);
      check({tag, "_last"},  128'(out_last),  128'h0);
      check({tag, "_data"},  out_data,        128'h0);
      check({tag, "_busy"},  128'(busy),      128'h0);
      check({tag, "_done"},  128'(done),      128'h0);
   endtask

   task automatic fill_mem(input bit random_data);
      for (int i = 0; i < 16; i++) begin
         for (int r = 0; r < 16; r++) begin
            if (random_data) mem[i][r] = $urandom;
            else mem[i][r] = {8'(i), 8'(r), 16'hA5A5};
         end
      end
   endtask

   // ready_mode: 0 always ready, 1 toggle every cycle, 2 random.
   // abort_at >= 0 asserts reset once that many beats have been accepted.
   task automatic run_drain(input logic [3:0] rm1, input int ready_mode, input bit poke_start,
                            input int abort_at);
      logic [127:0] exp_q[$];
      logic [127:0] exp_beat;
      logic [127:0] prev_data;
      logic         prev_last;
      bit           prev_stall;
      bit           fin;
      int           n_edge;
      int           n_acc;
      int           n_reads;
      int           n_done;
      int           first_valid;
      int           n_rows;

      n_rows = int'(rm1) + 1;
      for (int r = 0; r < n_rows; r++) begin
         for (int b = 0; b < 4; b++) begin
            exp_q.push_back({mem[4*b+3][r], mem[4*b+2][r], mem[4*b+1][r], mem[4*b][r]});
         end
      end

      @(negedge clk);
      start     = 1'b1;
      rows_m1   = rm1;
      out_ready = 1'b1;
      @(negedge clk);
      // n_edge counts edges since the one that sampled start
      start       = 1'b0;
      rows_m1     = ~rm1;
      n_edge      = 0;
      n_acc       = 0;
      n_reads     = 0;
      n_done      = 0;
      first_valid = -1;
      prev_stall  = 1'b0;
      prev_data   = '0;
      prev_last   = 1'b0;
      fin         = 1'b0;

      while (!fin && n_edge < 2000) begin
         if (abort_at >= 0 && n_acc == abort_at) begin
            check("abort_in_send", 128'(out_valid), 128'h1);
            rst_n = 1'b0;
            #1;
            check_reset_outputs("abort_rst");
            @(negedge clk);
            check_reset_outputs("abort_hold");
            rst_n = 1'b1;
            @(negedge clk);
            check("abort_no_done", 128'(done), 128'h0);
            return;
         end

         case (ready_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = n_edge[0];
            default: out_ready = 1'($urandom_range(0, 1));
         endcase
         start = poke_start && (n_acc == 1);

         check("wen_const", 128'(WEN), 128'hFFFF);
         if (CEN == 16'h0000) begin
            check("read_addr", 128'(A), 128'({16{4'(n_reads)}}));
            check("no_read_in_send", 128'(out_valid), 128'h0);
            n_reads++;
         end else begin
            check("cen_idle", 128'(CEN), 128'hFFFF);
         end

         if (out_valid && first_valid < 0) begin
            first_valid = n_edge;
            // third cycle after the sampling edge
            check("first_valid_lat", 128'(first_valid), 128'd2);
         end

         if (prev_stall) begin
            check("stall_data", out_data, prev_data);
            check("stall_last", 128'(out_last), 128'(prev_last));
         end

         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               check("extra_beat", 128'(out_valid), 128'h0);
            end else begin
               exp_beat = exp_q.pop_front();
               check("beat_data", out_data, exp_beat);
               check("beat_last", 128'(out_last), 128'(exp_q.size() == 0));
            end
            n_acc++;
         end else if (out_valid) begin
            check("last_on_stall", 128'(out_last),
                  128'(exp_q.size() == 1));
         end

         prev_stall = out_valid && !out_ready;
         prev_data  = out_data;
         prev_last  = out_last;

         if (done) begin
            n_done++;
            if (ready_mode == 0) check("done_cycle", 128'(n_edge), 128'(6 * n_rows));
            check("done_all_beats", 128'(exp_q.size()), 128'h0);
            check("done_idle", 128'(busy), 128'h0);
            fin = 1'b1;
         end else begin
            check("busy_high", 128'(busy), 128'h1);
         end

         @(negedge clk);
         n_edge++;
      end

      start = 1'b0;
      check("drain_finished", 128'(fin), 128'h1);
      check("read_count", 128'(n_reads), 128'(n_rows));
      check("done_count", 128'(n_done), 128'h1);

      // Quiet afterwards: no second done, no restart from an ignored start
      for (int k = 0; k < 6; k++) begin
         check("post_done", 128'(done), 128'h0);
         check("post_busy", 128'(busy), 128'h0);
         check("post_valid", 128'(out_valid), 128'h0);
         check("post_cen", 128'(CEN), 128'hFFFF);
         @(negedge clk);
      end
   endtask

   initial begin
      rst_n     = 1'b0;
      start     = 1'b0;
      rows_m1   = 4'd0;
      out_ready = 1'b0;
      for (int i = 0; i < 16; i++) q_r[i] = '0;
      fill_mem(1'b0);
      #1;
      check_reset_outputs("reset");
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      // Single row, always ready
      run_drain(4'd0, 0, 1'b0, -1);
      // All sixteen rows, checks no wrap and 96-cycle drain
      run_drain(4'd15, 0, 1'b0, -1);
      // Ready toggling every cycle
      run_drain(4'd1, 1, 1'b0, -1);
      // Start pulsed during SEND of row 0 must be ignored
      run_drain(4'd2, 0, 1'b1, -1);
      // Reset during SEND of row 2, then restart from row 0
      run_drain(4'd5, 0, 1'b0, 9);
      run_drain(4'd3, 0, 1'b0, -1);

      // Random contents, random lengths and backpressure
      fill_mem(1'b1);
      for (int t = 0; t < 4; t++) begin
         run_drain(4'($urandom_range(0, 15)), 2, 1'($urandom_range(0, 1)), -1);
      end
      run_drain(4'($urandom_range(0, 15)), 1, 1'b0, -1);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
